writeback_stage: RTL and testbench

Final pipeline stage and sole driver of the register-bank write port. It captures memory-stage results in a MEM/WB pipeline register and resolves the destination register (rt for I-type, rd for R-type). It selects the writeback value (ALU result or load data) and issues exactly one write strobe per retired instruction. It also supplies decode with same-cycle write-through bypass of rs/rt reads and keeps a saturating retired-write counter.

---
 rtl/writeback_stage.sv | 116 +++++++++++
 tb/tb_writeback_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, register-bank write port,
// decode write-through bypass and saturating retired-write counter.
// Optional feature macro: WB_BYPASS_EN (write-through bypass of rs/rt reads).
module writeback_stage (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic        mem_reg_write,
   input  logic        mem_reg_dest,
   input  logic        mem_mem_to_reg,
   input  logic [4:0]  mem_rt_id,
   input  logic [4:0]  mem_rd_id,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_load_data,
   output logic        reg_write,
   output logic [4:0]  reg_write_id,
   output logic [31:0] reg_write_value,
   input  logic [4:0]  dec_rs_id,
   input  logic [4:0]  dec_rt_id,
   input  logic [31:0] bank_rs_value,
   input  logic [31:0] bank_rt_value,
   output logic [31:0] dec_rs_value,
   output logic [31:0] dec_rt_value,
   output logic [31:0] retired_writes
);

   localparam int unsigned DataW = 32;
   localparam int unsigned IdW   = 5;

   logic             valid_q, valid_d;
   logic             rw_q, rw_d;
   logic             fresh_q, fresh_d;
   logic [IdW-1:0]   dest_q, dest_d;
   logic [DataW-1:0] value_q, value_d;
   logic [DataW-1:0] retired_q, retired_d;

   // MEM/WB next state: flush beats stall; fresh marks the first cycle of an entry
   always_comb begin
      valid_d = valid_q;
      rw_d    = rw_q;
      dest_d  = dest_q;
      value_d = value_q;
      fresh_d = 1'b0;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d = mem_valid;
         rw_d    = mem_reg_write;
         dest_d  = mem_reg_dest ? mem_rt_id : mem_rd_id;
         value_d = mem_mem_to_reg ? mem_load_data : mem_alu_result;
         fresh_d = 1'b1;
      end
   end

   // Write port: one strobe per retired entry, $zero destination suppressed
   always_comb begin
      reg_write       = valid_q & rw_q & fresh_q & (dest_q != IdW'(0));
      reg_write_id    = valid_q ? dest_q : IdW'(0);
      reg_write_value = valid_q ? value_q : DataW'(0);
   end

   // Retired-write counter saturates instead of wrapping
   always_comb begin
      retired_d = retired_q;
      if (reg_write && (retired_q != {DataW{1'b1}})) begin
         retired_d = retired_q + DataW'(1);
      end
   end

`ifdef WB_BYPASS_EN
   // Write-through bypass per read port; reg_write already excludes ID 0
   always_comb begin
      dec_rs_value = bank_rs_value;
      dec_rt_value = bank_rt_value;
      if (reg_write && (dec_rs_id == reg_write_id)) begin
         dec_rs_value = reg_write_value;
      end
      if (reg_write && (dec_rt_id == reg_write_id)) begin
         dec_rt_value = reg_write_value;
      end
   end
`else
   logic unused_dec_ids;

   // Bypass disabled: bank data passes straight through to decode
   always_comb begin
      dec_rs_value   = bank_rs_value;
      dec_rt_value   = bank_rt_value;
      unused_dec_ids = ^{dec_rs_id, dec_rt_id};
   end
`endif

   // State registers with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q   <= 1'b0;
         rw_q      <= 1'b0;
         fresh_q   <= 1'b0;
         dest_q    <= '0;
         value_q   <= '0;
         retired_q <= '0;
      end else begin
         valid_q   <= valid_d;
         rw_q      <= rw_d;
         fresh_q   <= fresh_d;
         dest_q    <= dest_d;
         value_q   <= value_d;
         retired_q <= retired_d;
      end
   end

   assign retired_writes = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed table, hand-written multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_writeback_stage;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall, flush;
   logic        mem_valid, mem_reg_write, mem_reg_dest, mem_mem_to_reg;
   logic [4:0]  mem_rt_id, mem_rd_id;
   logic [31:0] mem_alu_result, mem_load_data;
   logic        reg_write;
   logic [4:0]  reg_write_id;
   logic [31:0] reg_write_value;
   logic [4:0]  dec_rs_id, dec_rt_id;
   logic [31:0] bank_rs_value, bank_rt_value;
   logic [31:0] dec_rs_value, dec_rt_value;
   logic [31:0] retired_writes;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   writeback_stage dut (
      .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_reg_dest(mem_reg_dest), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_rt_id(mem_rt_id), .mem_rd_id(mem_rd_id),
      .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
      .reg_write(reg_write), .reg_write_id(reg_write_id),
      .reg_write_value(reg_write_value),
      .dec_rs_id(dec_rs_id), .dec_rt_id(dec_rt_id),
      .bank_rs_value(bank_rs_value), .bank_rt_value(bank_rt_value),
      .dec_rs_value(dec_rs_value), .dec_rt_value(dec_rt_value),
      .retired_writes(retired_writes)
   );

   always #5 clock = ~clock;

   // Behavioural model: the instruction currently in writeback and whether
   // it has already been retired (written) or not.
   bit              m_have;
   bit              m_writes;
   logic [4:0]      m_dest;
   logic [31:0]     m_val;
   bit              m_pending;
   longint unsigned m_count;

   function automatic bit exp_strobe();
      return m_have && m_writes && m_pending && (m_dest != 5'd0);
   endfunction

   function automatic logic [31:0] exp_dec(input logic [4:0] id, input logic [31:0] bank);
      bit hit;
      hit = exp_strobe() && (id == m_dest);
      return (BYP && hit) ? m_val : bank;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_have = 0; m_writes = 0; m_dest = '0; m_val = '0; m_pending = 0; m_count = 0;
   endtask

   // One clock edge: DUT and model both consume the current inputs
   task automatic tick();
      bit s;
      s = exp_strobe();
      @(posedge clock);
      if (s && m_count < 64'hFFFF_FFFF) m_count++;
      if (flush) begin
         m_have = 0; m_pending = 0;
      end else if (stall) begin
         m_pending = 0;
      end else begin
         m_have    = mem_valid;
         m_writes  = mem_reg_write;
         m_dest    = mem_reg_dest ? mem_rt_id : mem_rd_id;
         m_val     = mem_mem_to_reg ? mem_load_data : mem_alu_result;
         m_pending = 1;
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".we"}, 32'(reg_write), 32'(exp_strobe()));
      if (m_have) begin
         chk({tag, ".id"}, 32'(reg_write_id), 32'(m_dest));
         chk({tag, ".val"}, reg_write_value, m_val);
      end
      chk({tag, ".rs"}, dec_rs_value, exp_dec(dec_rs_id, bank_rs_value));
      chk({tag, ".rt"}, dec_rt_value, exp_dec(dec_rt_id, bank_rt_value));
      chk({tag, ".cnt"}, retired_writes, 32'(m_count));
   endtask

   task automatic drive(input bit v, input bit rw, input bit rdest, input bit m2r,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] ld);
      mem_valid = v; mem_reg_write = rw; mem_reg_dest = rdest; mem_mem_to_reg = m2r;
      mem_rt_id = rt; mem_rd_id = rd; mem_alu_result = alu; mem_load_data = ld;
   endtask

   typedef struct {
      bit          stl, fl, v, rw, rdest, m2r;
      logic [4:0]  rt, rd;
      logic [31:0] alu, ld;
      bit          exp_we;
      logic [4:0]  exp_id;
      logic [31:0] exp_val;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] c0;
      // stl fl v rw rdest m2r rt rd alu ld | we id val
      vecs[0] = '{0,0,1,1,0,0, 5'd1,  5'd5,  32'h0000_1234, 32'h0,          1, 5'd5,  32'h0000_1234};
      vecs[1] = '{0,0,1,1,1,1, 5'd9,  5'd3,  32'h0000_1111, 32'hDEAD_BEEF,  1, 5'd9,  32'hDEAD_BEEF};
      vecs[2] = '{0,0,1,1,0,0, 5'd4,  5'd0,  32'h0000_0042, 32'h0,          0, 5'd0,  32'h0};
      vecs[3] = '{0,0,1,1,1,0, 5'd0,  5'd4,  32'h0000_0043, 32'h0,          0, 5'd0,  32'h0};
      vecs[4] = '{0,0,1,0,0,0, 5'd2,  5'd20, 32'h0000_0044, 32'h0,          0, 5'd0,  32'h0};
      vecs[5] = '{0,0,0,1,0,0, 5'd2,  5'd6,  32'h0000_0045, 32'h0,          0, 5'd0,  32'h0};
      vecs[6] = '{0,0,1,1,1,0, 5'd17, 5'd8,  32'hAAAA_5555, 32'h1357_9BDF,  1, 5'd17, 32'hAAAA_5555};
      vecs[7] = '{0,0,1,1,0,1, 5'd11, 5'd30, 32'h2468_ACE0, 32'h0F0F_0F0F,  1, 5'd30, 32'h0F0F_0F0F};
      vecs[8] = '{0,1,1,1,0,0, 5'd1,  5'd8,  32'h0000_0099, 32'h0,          0, 5'd0,  32'h0};

      // Reset asserted, released mid-cycle while stalled: no entry appears
      reset_n = 1'b0; stall = 1'b1; flush = 1'b0;
      drive(1, 1, 0, 0, 5'd3, 5'd3, 32'h77, 32'h0);
      dec_rs_id = 5'd3; dec_rt_id = 5'd3; bank_rs_value = 32'h11; bank_rt_value = 32'h22;
      model_clear();
      #12;
      reset_n = 1'b1;
      tick(); check_model("rst_stall1");
      tick(); check_model("rst_stall2");
      stall = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         stall = vecs[i].stl; flush = vecs[i].fl;
         drive(vecs[i].v, vecs[i].rw, vecs[i].rdest, vecs[i].m2r,
               vecs[i].rt, vecs[i].rd, vecs[i].alu, vecs[i].ld);
         tick();
         chk($sformatf("vec%0d.we", i), 32'(reg_write), 32'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            chk($sformatf("vec%0d.id", i), 32'(reg_write_id), 32'(vecs[i].exp_id));
            chk($sformatf("vec%0d.val", i), reg_write_value, vecs[i].exp_val);
         end
         check_model($sformatf("vec%0d", i));
      end
      stall = 1'b0; flush = 1'b0;

      // Capture then stall 3 cycles: exactly one strobe, counter +1
      c0 = retired_writes;
      drive(1, 1, 0, 0, 5'd1, 5'd7, 32'h0000_0777, 32'h0);
      tick(); chk("stall.first_we", 32'(reg_write), 32'd1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(); chk($sformatf("stall.hold%0d_we", k), 32'(reg_write), 32'd0);
         check_model("stall");
      end
      chk("stall.cnt", retired_writes, c0 + 32'd1);
      // Flush together with stall on the next capture: no strobe
      flush = 1'b1;
      drive(1, 1, 0, 0, 5'd1, 5'd9, 32'h0000_0999, 32'h0);
      tick(); chk("flush_stall.we", 32'(reg_write), 32'd0);
      stall = 1'b0; flush = 1'b0;
      drive(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      tick(); chk("flush_stall.cnt", retired_writes, c0 + 32'd1);
      check_model("flush_stall");

      // Bypass to r12; rt port reading r0 never bypassed
      drive(1, 1, 0, 0, 5'd12, 5'd12, 32'hCAFE_F00D, 32'h0);
      tick();
      dec_rs_id = 5'd12; bank_rs_value = 32'h0;
      dec_rt_id = 5'd0;  bank_rt_value = 32'h5A5A_0001;
      #1;
      chk("byp.rs", dec_rs_value, BYP ? 32'hCAFE_F00D : 32'h0);
      chk("byp.rt0", dec_rt_value, 32'h5A5A_0001);
      dec_rt_id = 5'd12; bank_rt_value = 32'h0000_0BAD;
      #1;
      chk("byp.rt12", dec_rt_value, BYP ? 32'hCAFE_F00D : 32'h0000_0BAD);
      check_model("byp");

      // Back-to-back writes to same ID: each strobes once, bypass follows
      drive(1, 1, 0, 0, 5'd0, 5'd12, 32'h0000_0A01, 32'h0);
      tick(); check_model("b2b1");
      drive(1, 1, 0, 0, 5'd0, 5'd12, 32'h0000_0A02, 32'h0);
      tick(); check_model("b2b2");

      // Asynchronous reset pulse mid-run
      #2 reset_n = 1'b0;
      #1;
      model_clear();
      chk("rst.we", 32'(reg_write), 32'd0);
      chk("rst.id", 32'(reg_write_id), 32'd0);
      chk("rst.val", reg_write_value, 32'd0);
      chk("rst.cnt", retired_writes, 32'd0);
      chk("rst.rs", dec_rs_value, bank_rs_value);
      chk("rst.rt", dec_rt_value, bank_rt_value);
      #2 reset_n = 1'b1;
      drive(1, 1, 0, 0, 5'd2, 5'd5, 32'h0000_1234, 32'h0);
      tick();
      chk("post_rst.we", 32'(reg_write), 32'd1);
      chk("post_rst.id", 32'(reg_write_id), 32'd5);
      chk("post_rst.val", reg_write_value, 32'h0000_1234);
      check_model("post_rst");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
         dec_rs_id = 5'($urandom_range(0, 7)); dec_rt_id = 5'($urandom_range(0, 7));
         bank_rs_value = $urandom; bank_rt_value = $urandom;
         tick();
         check_model("rand");
      end
      stall = 1'b0; flush = 1'b0;

      // Saturation: preload the counter near the top, then issue 3 writes
      drive(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      force dut.retired_q = 32'hFFFF_FFFE;
      #1;
      release dut.retired_q;
      m_count = 64'hFFFF_FFFE;
      chk("sat.preload", retired_writes, 32'hFFFF_FFFE);
      for (int k = 1; k <= 3; k++) begin
         drive(1, 1, 0, 0, 5'd0, 5'(k), 32'(k), 32'h0);
         tick(); check_model("sat.wr");
      end
      drive(0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0);
      tick(); chk("sat.cnt", retired_writes, 32'hFFFF_FFFF);
      tick(); chk("sat.hold", retired_writes, 32'hFFFF_FFFF);
      check_model("sat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
